// File: rtl/led_pkg.sv
// Shared types and constants for the LED running-light control chain.
package led_pkg;

    localparam int unsigned CLK_HZ = 50_000_000;
    localparam int          SPD_W  = 2;

    typedef logic [SPD_W-1:0] speed_t;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_FLT,
        DOWN,
        REL_FLT
    } deb_state_t;

endpackage

// File: rtl/led_speed_ctrl_if.sv
// Key input and speed/step outputs of led_speed_ctrl; master drives the key, slave is the controller.
interface led_speed_ctrl_if;
    import led_pkg::*;

    logic   key_in;
    logic   step_tick;
    speed_t speed_lvl;
    logic   key_flag;

    modport master (output key_in, input step_tick, speed_lvl, key_flag);
    modport slave  (input key_in, output step_tick, speed_lvl, key_flag);

endinterface

// File: rtl/led_speed_ctrl_key_debounce.sv
// Key synchroniser plus press/release debounce FSM; emits one key_flag per accepted press.
// With LONG_PRESS_EN defined, also exports 'held' (debounced key is down).
module key_debounce
    import led_pkg::*;
#(
    parameter logic [19:0] DEB_MAX = 20'(CLK_HZ / 50 - 1)
)(
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic key_in,
    output logic key_flag
`ifdef LONG_PRESS_EN
    ,output logic held
`endif
);

    logic        key_meta;
    logic        key_s;
    deb_state_t  state, state_nxt;
    logic [19:0] cnt, cnt_nxt;
    logic        flag_nxt;

    // Sync FFs reset to the released level, so a key held through reset looks like a fresh press.
    // NOTE: clocked state uses <= so every register samples pre-edge values regardless of statement order.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            key_meta <= 1'b1;
            key_s    <= 1'b1;
        end else begin
            key_meta <= key_in;
            key_s    <= key_meta;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            key_flag <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            key_flag <= flag_nxt;
        end
    end

    // NOTE: defaults first, so every path through the case assigns every output and no latch is inferred.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        flag_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (!key_s) begin
                    state_nxt = PRESS_FLT;
                    cnt_nxt   = '0;
                end
            end
            PRESS_FLT: begin
                if (key_s) begin
                    state_nxt = IDLE;
                end else if (cnt == DEB_MAX) begin
                    state_nxt = DOWN;
                    flag_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + 20'd1;
                end
            end
            DOWN: begin
                if (key_s) begin
                    state_nxt = REL_FLT;
                    cnt_nxt   = '0;
                end
            end
            REL_FLT: begin
                if (!key_s) begin
                    state_nxt = DOWN;
                end else if (cnt == DEB_MAX) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + 20'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef LONG_PRESS_EN
    assign held = (state == DOWN);
`endif

endmodule

// File: rtl/led_speed_ctrl.sv
// Speed-level register and level-dependent step strobe for the running-LED chain.
// Optional LONG_PRESS_EN: holding the key for LONG_MAX+1 cycles drops the level back to 0.
module led_speed_ctrl
    import led_pkg::*;
#(
    parameter logic [19:0] DEB_MAX   = 20'(CLK_HZ / 50 - 1),
    parameter logic [25:0] TICK_BASE = 26'(CLK_HZ)
`ifdef LONG_PRESS_EN
    ,parameter logic [25:0] LONG_MAX = 26'(CLK_HZ - 1)
`endif
)(
    input logic             sys_clk,
    input logic             sys_rst_n,
    led_speed_ctrl_if.slave bus
);

    logic        key_flag;
    speed_t      speed_lvl;
    logic [25:0] step_cnt;
    logic [25:0] period_m1;
    logic        step_tick;
    logic        long_hit;

`ifdef LONG_PRESS_EN
    logic        held;
    logic        hold_done;
    logic [25:0] hold_cnt;
`endif

    key_debounce #(
        .DEB_MAX (DEB_MAX)
    ) u_key_debounce (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .key_in    (bus.key_in),
        .key_flag  (key_flag)
`ifdef LONG_PRESS_EN
        ,.held     (held)
`endif
    );

`ifdef LONG_PRESS_EN
    // Fires once per hold; the counter then parks until the key is released.
    assign long_hit = held && !hold_done && (hold_cnt == LONG_MAX);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            hold_cnt  <= '0;
            hold_done <= 1'b0;
        end else if (!held) begin
            hold_cnt  <= '0;
            hold_done <= 1'b0;
        end else if (long_hit) begin
            hold_done <= 1'b1;
        end else if (!hold_done) begin
            hold_cnt <= hold_cnt + 26'd1;
        end
    end
`else
    assign long_hit = 1'b0;
`endif

    assign period_m1 = (TICK_BASE >> speed_lvl) - 26'd1;

    // Any level change restarts the period, so the first tick at a new level is a full P_new away.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            speed_lvl <= '0;
            step_cnt  <= '0;
            step_tick <= 1'b0;
        end else if (long_hit) begin
            speed_lvl <= '0;
            step_cnt  <= '0;
            step_tick <= 1'b0;
        end else if (key_flag) begin
            speed_lvl <= speed_lvl + speed_t'(1);
            step_cnt  <= '0;
            step_tick <= 1'b0;
        end else if (step_cnt == period_m1) begin
            step_cnt  <= '0;
            step_tick <= 1'b1;
        end else begin
            step_cnt  <= step_cnt + 26'd1;
            step_tick <= 1'b0;
        end
    end

    assign bus.step_tick = step_tick;
    assign bus.speed_lvl = speed_lvl;
    assign bus.key_flag  = key_flag;

endmodule
